// File: rtl/sdram_init.sv
// SDRAM power-up initialisation sequencer: stable wait, PRECHARGE ALL, AREF_NUM
// auto-refreshes, MODE REGISTER SET, then init_end. All outputs are registered.
module sdram_init #(
  parameter int ADDR_W   = 13,
  parameter int WAIT_CYC = 33200,
  parameter int TRP_CYC  = 3,
  parameter int TRFC_CYC = 10,
  parameter int TMRD_CYC = 2,
  parameter int AREF_NUM = 8,
  parameter logic [ADDR_W-1:0] MODE_REG = ADDR_W'(13'h0032)
) (
  input  logic              sclk,
  input  logic              srst_n,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_end,
  output logic              sdr_cke,
  output logic [3:0]        sdr_cmd,
  output logic [1:0]        sdr_ba,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic [3:0]        aref_cnt
);

  localparam int MAX_A   = (WAIT_CYC > TRP_CYC) ? WAIT_CYC : TRP_CYC;
  localparam int MAX_B   = (TRFC_CYC > TMRD_CYC) ? TRFC_CYC : TMRD_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] AREF_MAX = 4'(AREF_NUM);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_PRE, S_TRP, S_AREF, S_TRFC, S_MRS, S_TMRD, S_DONE
  } state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [3:0]          cmd_n;
  logic [ADDR_W-1:0]   addr_n;

  // Spacing states hold for (spacing - 1) cycles; a spacing of 1 skips the
  // wait state entirely so commands go back-to-back.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: if (init_start) begin
        state_n = S_WAIT;
        cnt_n   = CW'(WAIT_CYC - 1);
      end
      S_WAIT: if (cnt == '0) state_n = S_PRE; else cnt_n = cnt - 1'b1;
      S_PRE: if (TRP_CYC > 1) begin
        state_n = S_TRP;
        cnt_n   = CW'(TRP_CYC - 2);
      end else state_n = S_AREF;
      S_TRP: if (cnt == '0) state_n = S_AREF; else cnt_n = cnt - 1'b1;
      S_AREF: if (TRFC_CYC > 1) begin
        state_n = S_TRFC;
        cnt_n   = CW'(TRFC_CYC - 2);
      end else state_n = (aref_cnt < AREF_MAX) ? S_AREF : S_MRS;
      S_TRFC: if (cnt == '0) state_n = (aref_cnt < AREF_MAX) ? S_AREF : S_MRS;
              else cnt_n = cnt - 1'b1;
      S_MRS: if (TMRD_CYC > 1) begin
        state_n = S_TMRD;
        cnt_n   = CW'(TMRD_CYC - 2);
      end else state_n = S_DONE;
      S_TMRD: if (cnt == '0) state_n = S_DONE; else cnt_n = cnt - 1'b1;
      S_DONE: if (!init_start) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered bus lines up
  // with the state occupying the same cycle.
  always_comb begin
    cmd_n  = CMD_NOP;
    addr_n = '0;
    case (state_n)
      S_PRE: begin
        cmd_n      = CMD_PRE;
        addr_n[10] = 1'b1;
      end
      S_AREF: cmd_n = CMD_AREF;
      S_MRS: begin
        cmd_n  = CMD_MRS;
        addr_n = MODE_REG;
      end
      default: cmd_n = CMD_NOP;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sdr_cmd   <= CMD_NOP;
      sdr_ba    <= '0;
      sdr_addr  <= '0;
      sdr_cke   <= 1'b0;
      init_end  <= 1'b0;
      init_busy <= 1'b0;
      aref_cnt  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sdr_cmd   <= cmd_n;
      sdr_ba    <= '0;
      sdr_addr  <= addr_n;
      sdr_cke   <= sdr_cke | (state_n == S_WAIT);
      init_end  <= (state_n == S_DONE);
      init_busy <= (state_n != S_IDLE) && (state_n != S_DONE);
      if (state == S_IDLE && state_n == S_WAIT) aref_cnt <= '0;
      else if (state_n == S_AREF && aref_cnt < AREF_MAX) aref_cnt <= aref_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_init.sv
// Bench for sdram_init: three parameterisations checked every cycle against a
// timeline model built from the command-time formulas, plus literal spot checks.
module tb_sdram_init;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int p_w[ND]    = '{10, 1, 33200};
  int p_trp[ND]  = '{3, 1, 3};
  int p_trfc[ND] = '{10, 1, 10};
  int p_tmrd[ND] = '{2, 1, 2};
  int p_n[ND]    = '{8, 1, 8};

  logic        srst_n[ND];
  logic        init_start[ND];
  logic        busy[ND];
  logic        iend[ND];
  logic        cke[ND];
  logic [3:0]  cmd[ND];
  logic [1:0]  ba[ND];
  logic [12:0] addr[ND];
  logic [3:0]  aref[ND];

  sdram_init #(.WAIT_CYC(10)) u_dut0 (
    .sclk(clk), .srst_n(srst_n[0]), .init_start(init_start[0]), .init_busy(busy[0]),
    .init_end(iend[0]), .sdr_cke(cke[0]), .sdr_cmd(cmd[0]), .sdr_ba(ba[0]),
    .sdr_addr(addr[0]), .aref_cnt(aref[0]));

  sdram_init #(.WAIT_CYC(1), .TRP_CYC(1), .TRFC_CYC(1), .TMRD_CYC(1), .AREF_NUM(1)) u_dut1 (
    .sclk(clk), .srst_n(srst_n[1]), .init_start(init_start[1]), .init_busy(busy[1]),
    .init_end(iend[1]), .sdr_cke(cke[1]), .sdr_cmd(cmd[1]), .sdr_ba(ba[1]),
    .sdr_addr(addr[1]), .aref_cnt(aref[1]));

  sdram_init u_dut2 (
    .sclk(clk), .srst_n(srst_n[2]), .init_start(init_start[2]), .init_busy(busy[2]),
    .init_end(iend[2]), .sdr_cke(cke[2]), .sdr_cmd(cmd[2]), .sdr_ba(ba[2]),
    .sdr_addr(addr[2]), .aref_cnt(aref[2]));

  int n_chk  = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  // Model: idle / running at cycle t since start / done.
  bit m_run[ND]  = '{0, 0, 0};
  bit m_done[ND] = '{0, 0, 0};
  bit m_cke[ND]  = '{0, 0, 0};
  int m_t[ND]    = '{0, 0, 0};
  int m_aref[ND] = '{0, 0, 0};

  task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s dut%0d @%0t: got %h expected %h", name, d, $time, got, exp);
    end
  endtask

  function automatic int pre_t(int d);
    return p_w[d] + 1;
  endfunction

  function automatic int end_t(int d);
    return pre_t(d) + p_trp[d] + p_n[d] * p_trfc[d] + p_tmrd[d];
  endfunction

  function automatic int aref_count(int d, int t);
    int c = 0;
    for (int k = 1; k <= p_n[d]; k++)
      if (t >= pre_t(d) + p_trp[d] + (k - 1) * p_trfc[d]) c++;
    return c;
  endfunction

  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      if (!srst_n[d]) begin
        m_run[d] = 0; m_done[d] = 0; m_cke[d] = 0; m_aref[d] = 0;
      end else if (m_done[d]) begin
        if (!init_start[d]) m_done[d] = 0;
      end else if (m_run[d]) begin
        m_t[d]++;
        if (m_t[d] == end_t(d)) begin
          m_run[d] = 0; m_done[d] = 1; m_aref[d] = p_n[d];
        end
      end else if (init_start[d]) begin
        m_run[d] = 1; m_t[d] = 1; m_cke[d] = 1;
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < ND; d++) begin
      logic [3:0]  e_cmd  = 4'b0111;
      logic [12:0] e_addr = '0;
      int          e_ar   = m_aref[d];
      if (m_run[d]) begin
        int t = m_t[d];
        e_ar = aref_count(d, t);
        if (t == pre_t(d)) begin
          e_cmd = 4'b0010; e_addr = 13'h0400;
        end
        for (int k = 1; k <= p_n[d]; k++)
          if (t == pre_t(d) + p_trp[d] + (k - 1) * p_trfc[d]) e_cmd = 4'b0001;
        if (t == pre_t(d) + p_trp[d] + p_n[d] * p_trfc[d]) begin
          e_cmd = 4'b0000; e_addr = 13'h0032;
        end
      end
      chk("cmd", d, 32'(cmd[d]), 32'(e_cmd));
      chk("addr", d, 32'(addr[d]), 32'(e_addr));
      chk("ba", d, 32'(ba[d]), 32'd0);
      chk("cke", d, 32'(cke[d]), 32'(m_cke[d]));
      chk("busy", d, 32'(busy[d]), 32'(m_run[d]));
      chk("init_end", d, 32'(iend[d]), 32'(m_done[d]));
      chk("aref_cnt", d, 32'(aref[d]), 32'(e_ar));
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (checking) compare_all();
  end

  task automatic wait_idle(input int d);
    int k = 0;
    while ((busy[d] || iend[d]) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", d, 32'(k < 200), 32'd1);
  endtask

  task automatic run_dut0();
    // Test 1 and 2: full sequence, then hold init_start 5 cycles past init_end
    @(negedge clk); init_start[0] = 1;
    repeat (11) @(negedge clk);
    chk("t1_pre_cmd", 0, 32'(cmd[0]), 32'h2);
    chk("t1_pre_a10", 0, 32'(addr[0][10]), 32'd1);
    repeat (3) @(negedge clk);
    chk("t1_aref1", 0, 32'(cmd[0]), 32'h1);
    repeat (80) @(negedge clk);
    chk("t1_mrs_cmd", 0, 32'(cmd[0]), 32'h0);
    chk("t1_mrs_addr", 0, 32'(addr[0]), 32'h32);
    @(negedge clk);
    chk("t1_end_95", 0, 32'(iend[0]), 32'd0);
    @(negedge clk);
    chk("t1_end_96", 0, 32'(iend[0]), 32'd1);
    repeat (5) @(negedge clk);
    chk("t2_end_held", 0, 32'(iend[0]), 32'd1);
    init_start[0] = 0;
    @(negedge clk);
    chk("t2_end_clr", 0, 32'(iend[0]), 32'd0);
    chk("t2_cke", 0, 32'(cke[0]), 32'd1);
    // Test 3: short init_start pulse
    init_start[0] = 1;
    repeat (3) @(negedge clk);
    init_start[0] = 0;
    repeat (93) @(negedge clk);
    chk("t3_end_96", 0, 32'(iend[0]), 32'd1);
    @(negedge clk);
    chk("t3_end_97", 0, 32'(iend[0]), 32'd0);
    // Test 4: reset in the middle of the refresh phase
    repeat (2) @(negedge clk);
    init_start[0] = 1;
    repeat (50) @(negedge clk);
    srst_n[0] = 0;
    @(negedge clk);
    chk("t4_rst_cmd", 0, 32'(cmd[0]), 32'h7);
    chk("t4_rst_cke", 0, 32'(cke[0]), 32'd0);
    chk("t4_rst_aref", 0, 32'(aref[0]), 32'd0);
    srst_n[0] = 1;
    repeat (14) @(negedge clk);
    chk("t4_aref1", 0, 32'(cmd[0]), 32'h1);
    chk("t4_aref_cnt", 0, 32'(aref[0]), 32'd1);
    repeat (82) @(negedge clk);
    chk("t4_end_96", 0, 32'(iend[0]), 32'd1);
    init_start[0] = 0;
    @(negedge clk);
    // Randomised rounds: start holds, drops and resets at arbitrary points
    for (int r = 0; r < 12; r++) begin
      int hold   = $urandom_range(1, 130);
      bit do_rst = ($urandom_range(0, 3) == 0);
      int rst_at = $urandom_range(1, 100);
      int last   = do_rst && (rst_at + 1 > hold) ? rst_at + 1 : hold;
      init_start[0] = 0;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      init_start[0] = 1;
      for (int c = 1; c <= last; c++) begin
        @(negedge clk);
        srst_n[0] = !(do_rst && c == rst_at);
        if (c >= hold) init_start[0] = 0;
      end
      srst_n[0] = 1;
      init_start[0] = 0;
      @(negedge clk);
      wait_idle(0);
    end
  endtask

  task automatic run_dut1();
    // Test 5: all spacings 1, commands back-to-back
    @(negedge clk); init_start[1] = 1;
    repeat (2) @(negedge clk);
    chk("t5_pre", 1, 32'(cmd[1]), 32'h2);
    @(negedge clk);
    chk("t5_aref", 1, 32'(cmd[1]), 32'h1);
    @(negedge clk);
    chk("t5_mrs", 1, 32'(cmd[1]), 32'h0);
    @(negedge clk);
    chk("t5_end", 1, 32'(iend[1]), 32'd1);
    init_start[1] = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_dut2();
    // Test 6: default timing
    @(negedge clk); init_start[2] = 1;
    @(negedge clk);
    chk("t6_cke_1", 2, 32'(cke[2]), 32'd1);
    repeat (33200) @(negedge clk);
    chk("t6_pre", 2, 32'(cmd[2]), 32'h2);
    repeat (84) @(negedge clk);
    chk("t6_end_33285", 2, 32'(iend[2]), 32'd0);
    @(negedge clk);
    chk("t6_end_33286", 2, 32'(iend[2]), 32'd1);
    chk("t6_aref_cnt", 2, 32'(aref[2]), 32'd8);
    init_start[2] = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      srst_n[d] = 0;
      init_start[d] = 0;
    end
    repeat (3) @(negedge clk);
    checking = 1;
    for (int d = 0; d < ND; d++) begin
      chk("reset_cmd", d, 32'(cmd[d]), 32'h7);
      chk("reset_cke", d, 32'(cke[d]), 32'd0);
      chk("reset_aref", d, 32'(aref[d]), 32'd0);
      srst_n[d] = 1;
    end
    fork
      run_dut0();
      run_dut1();
      run_dut2();
    join
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
